// File: rtl/sao_deci_offset_seq.sv
// Per-CTU sequencer for the SAO offset decision: walks EO/BO/merge slots per enabled
// component, issues stats-buffer reads and re-times slot/component to the returned data.
module sao_deci_offset_seq #(
  parameter int state_len = 6,
  parameter int N_EO      = 16,
  parameter int N_BO      = 8,
  parameter int N_MRG     = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 start,
  input  logic [2:0]           comp_mask,
  input  logic                 hold,
  input  logic                 abort,
  output logic                 stat_rd_en,
  output logic [state_len+1:0] stat_rd_addr,
  output logic                 en,
  output logic [state_len-1:0] cnt_dc,
  output logic [1:0]           cIdx,
  output logic                 ofs_clr_n,
  output logic                 busy,
  output logic                 done
);

  localparam int LAST = N_EO + N_BO + N_MRG - 1;
  localparam logic [state_len-1:0] LAST_CNT = state_len'(LAST);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_ISSUE, S_DRAIN} state_t;

  state_t               r_state;
  logic [2:0]           r_mask;
  logic [1:0]           r_cidx_cnt;
  logic [state_len-1:0] r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_clr_n;
  logic [RD_LAT:1]      r_vld;
  logic [state_len+1:0] r_pa [1:RD_LAT];

  logic                 w_flush;
  logic                 w_rd_en;
  logic                 w_last;
  logic                 w_pipe_empty_nxt;
  logic [2:0]           w_above;
  logic                 w_has_next;
  logic [1:0]           w_next_c;

  function automatic logic [1:0] low_bit(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  function automatic logic [2:0] bits_above(input logic [2:0] m, input logic [1:0] c);
    case (c)
      2'd0:    return {m[2:1], 1'b0};
      2'd1:    return {m[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  assign w_flush    = abort && (r_state != S_IDLE);
  // hold and abort gate the issue combinationally so a held cycle never reads
  assign w_rd_en    = (r_state == S_ISSUE) && !hold && !abort;
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_above    = bits_above(r_mask, r_cidx_cnt);
  assign w_has_next = |w_above;
  assign w_next_c   = low_bit(w_above);

  // True when nothing will be left in the delay pipe after this edge
  always_comb begin
    w_pipe_empty_nxt = !w_rd_en;
    for (int i = 1; i < RD_LAT; i++)
      if (r_vld[i]) w_pipe_empty_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_cidx_cnt <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_clr_n    <= 1'b1;
    end else if (w_flush) begin
      r_state    <= S_IDLE;
      r_cidx_cnt <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_clr_n    <= 1'b1;
    end else begin
      r_clr_n <= 1'b1;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (start && !abort) begin
            r_mask  <= comp_mask;
            r_state <= S_CLR;
            r_busy  <= 1'b1;
            r_clr_n <= 1'b0;
          end
        end
        S_CLR: begin
          if (r_mask == 3'b000) begin
            r_state <= S_DRAIN;
            r_done  <= w_pipe_empty_nxt;
          end else begin
            r_cidx_cnt <= low_bit(r_mask);
            r_cnt      <= '0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_rd_en) begin
            if (w_last) begin
              r_cnt <= '0;
              if (w_has_next) begin
                r_cidx_cnt <= w_next_c;
              end else begin
                r_state <= S_DRAIN;
                r_done  <= w_pipe_empty_nxt;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // done is raised for the first cycle the pipe is empty; leave right after it
          if (r_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_done <= w_pipe_empty_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-latency delay pipe: address stages only advance with a valid beat
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_vld <= '0;
      for (int i = 1; i <= RD_LAT; i++) r_pa[i] <= '0;
    end else if (w_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[1] <= w_rd_en;
      for (int i = 2; i <= RD_LAT; i++) r_vld[i] <= r_vld[i-1];
      if (w_rd_en) r_pa[1] <= stat_rd_addr;
      for (int i = 2; i <= RD_LAT; i++)
        if (r_vld[i-1]) r_pa[i] <= r_pa[i-1];
    end
  end

  assign stat_rd_en   = w_rd_en;
  assign stat_rd_addr = {r_cidx_cnt, r_cnt};
  assign en           = r_vld[RD_LAT];
  assign cIdx         = r_pa[RD_LAT][state_len+1:state_len];
  assign cnt_dc       = r_pa[RD_LAT][state_len-1:0];
  assign ofs_clr_n    = r_clr_n;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_sao_deci_offset_seq.sv
// Bench for sao_deci_offset_seq: two instances (read latency 1 and 3) share stimulus;
// expected slot order, alignment and pass timing come from a slot-list model.
module tb_sao_deci_offset_seq;

  localparam int SL   = 6;
  localparam int NS   = 32;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic arst, start, hold, abort;
  logic [2:0] comp_mask;
  logic rd_en0, rd_en1, en0, en1, clrn0, clrn1, busy0, busy1, done0, done1;
  logic [SL+1:0] addr0, addr1;
  logic [SL-1:0] cnt0, cnt1;
  logic [1:0] ci0, ci1;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int q_rd0[$];
  int q_rd1[$];
  int q_en0[$];
  int q_en1[$];
  int n_done0 = 0, n_done1 = 0, done_cyc0 = 0, done_cyc1 = 0;
  int n_busy0 = 0, n_busy1 = 0, n_clr0 = 0, clr_cyc0 = 0;

  sao_deci_offset_seq #(.state_len(SL), .N_EO(16), .N_BO(8), .N_MRG(8), .RD_LAT(LAT0)) u_dut0 (
    .clk(clk), .arst(arst), .start(start), .comp_mask(comp_mask), .hold(hold), .abort(abort),
    .stat_rd_en(rd_en0), .stat_rd_addr(addr0), .en(en0), .cnt_dc(cnt0), .cIdx(ci0),
    .ofs_clr_n(clrn0), .busy(busy0), .done(done0));

  sao_deci_offset_seq #(.state_len(SL), .N_EO(16), .N_BO(8), .N_MRG(8), .RD_LAT(LAT1)) u_dut1 (
    .clk(clk), .arst(arst), .start(start), .comp_mask(comp_mask), .hold(hold), .abort(abort),
    .stat_rd_en(rd_en1), .stat_rd_addr(addr1), .en(en1), .cnt_dc(cnt1), .cIdx(ci1),
    .ofs_clr_n(clrn1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log: each entry is cycle*1024 + {cIdx, cnt}
  always @(negedge clk) begin
    if (rd_en0) q_rd0.push_back(cyc * 1024 + int'(addr0));
    if (rd_en1) q_rd1.push_back(cyc * 1024 + int'(addr1));
    if (en0) q_en0.push_back(cyc * 1024 + int'({ci0, cnt0}));
    if (en1) q_en1.push_back(cyc * 1024 + int'({ci1, cnt1}));
    if (done0) begin n_done0 <= n_done0 + 1; done_cyc0 <= cyc; end
    if (done1) begin n_done1 <= n_done1 + 1; done_cyc1 <= cyc; end
    if (busy0) n_busy0 <= n_busy0 + 1;
    if (busy1) n_busy1 <= n_busy1 + 1;
    if (!clrn0) begin n_clr0 <= n_clr0 + 1; clr_cyc0 <= cyc; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int top_bit(input logic [2:0] m);
    if (m[2]) return 2;
    if (m[1]) return 1;
    return 0;
  endfunction

  // One CTU pass; hmode 0 = no hold, 1 = toggling hold, 2 = random hold.
  // abort_idx >= 0 aborts in the cycle that would issue read number abort_idx.
  task automatic run_pass(input logic [2:0] mask, input int hmode, input int abort_idx,
                          input bit repulse);
    int t0, a_cyc, bd0, bd1, bb0, bb1, bc0, last_rd, iter, lat, exp_d;
    bit aborted, fin;
    int exp_a[$];
    int exp_e[$];
    @(posedge clk); #1;
    q_rd0.delete(); q_rd1.delete(); q_en0.delete(); q_en1.delete();
    bd0 = n_done0; bd1 = n_done1; bb0 = n_busy0; bb1 = n_busy1; bc0 = n_clr0;
    aborted = 1'b0; a_cyc = 0; fin = 1'b0;
    for (int c = 0; c < 3; c++)
      if (mask[c]) for (int n = 0; n < NS; n++) exp_a.push_back(c * 64 + n);
    comp_mask = mask; start = 1'b1; hold = 1'b0; abort = 1'b0; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; comp_mask = 3'($urandom);
    iter = 0;
    while (!fin && iter < 600) begin
      iter++;
      case (hmode)
        1:       hold = iter[0];
        2:       hold = 1'($urandom_range(0, 1));
        default: hold = 1'b0;
      endcase
      abort = 1'b0;
      if (abort_idx >= 0 && !aborted && q_rd0.size() == abort_idx) begin
        abort = 1'b1; aborted = 1'b1; a_cyc = cyc;
      end
      if (repulse && iter == 6) begin start = 1'b1; comp_mask = 3'b010; end
      else start = 1'b0;
      @(negedge clk);
      if (aborted && cyc == a_cyc + 1) begin
        chk("abort_busy0", busy0, 0);
        chk("abort_busy1", busy1, 0);
        chk("abort_en0", en0, 0);
        chk("abort_en1", en1, 0);
      end
      @(posedge clk); #1;
      if (n_done0 > bd0 && n_done1 > bd1) fin = 1'b1;
      if (aborted && cyc > a_cyc + 8) fin = 1'b1;
    end
    chk("pass_terminates", fin, 1);
    hold = 1'b0; abort = 1'b0; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    if (aborted) while (exp_a.size() > abort_idx) void'(exp_a.pop_back());
    chk("n_reads0", q_rd0.size(), exp_a.size());
    chk("n_reads1", q_rd1.size(), exp_a.size());
    foreach (exp_a[i]) begin
      if (i < q_rd0.size()) begin
        chk("rd_addr0", q_rd0[i] % 1024, exp_a[i]);
        if (hmode == 0) chk("rd_cycle0", q_rd0[i] / 1024, t0 + 2 + i);
      end
      if (i < q_rd1.size()) chk("rd_addr1", q_rd1[i] % 1024, exp_a[i]);
    end

    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? LAT0 : LAT1;
      exp_e.delete();
      foreach (q_rd0[i])
        if (!aborted || (q_rd0[i] / 1024 + lat <= a_cyc)) exp_e.push_back(q_rd0[i] + lat * 1024);
      if (k == 0) begin
        chk("n_en0", q_en0.size(), exp_e.size());
        foreach (exp_e[j]) if (j < q_en0.size()) chk("en_align0", q_en0[j], exp_e[j]);
      end else begin
        chk("n_en1", q_en1.size(), exp_e.size());
        foreach (exp_e[j]) if (j < q_en1.size()) chk("en_align1", q_en1[j], exp_e[j]);
      end
    end

    if (aborted) begin
      chk("no_done0", n_done0 - bd0, 0);
      chk("no_done1", n_done1 - bd1, 0);
      chk("busy_len_abort", n_busy0 - bb0, a_cyc - t0);
    end else begin
      last_rd = (q_rd0.size() > 0) ? q_rd0[q_rd0.size() - 1] / 1024 : t0;
      chk("done_once0", n_done0 - bd0, 1);
      chk("done_once1", n_done1 - bd1, 1);
      exp_d = (mask == 3'b000) ? t0 + 2 : last_rd + 1 + LAT0;
      chk("done_cycle0", done_cyc0, exp_d);
      chk("busy_len0", n_busy0 - bb0, exp_d - t0);
      exp_d = (mask == 3'b000) ? t0 + 2 : last_rd + 1 + LAT1;
      chk("done_cycle1", done_cyc1, exp_d);
      chk("busy_len1", n_busy1 - bb1, exp_d - t0);
      if (mask != 3'b000) begin
        chk("slot_hold0", int'({ci0, cnt0}), top_bit(mask) * 64 + NS - 1);
        chk("slot_hold1", int'({ci1, cnt1}), top_bit(mask) * 64 + NS - 1);
      end
    end
    chk("clr_once", n_clr0 - bc0, 1);
    chk("clr_cycle", clr_cyc0, t0 + 1);
  endtask

  initial begin
    int g, bc;
    logic [2:0] m;
    arst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; comp_mask = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", rd_en0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_en0", en0, 0);
    chk("rst_en1", en1, 0);
    chk("rst_cnt_dc", cnt0, 0);
    chk("rst_cidx", ci0, 0);
    chk("rst_clr_n0", clrn0, 1);
    chk("rst_clr_n1", clrn1, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    arst = 1'b0;

    run_pass(3'b001, 0, -1, 1'b0);
    run_pass(3'b101, 0, -1, 1'b1);
    run_pass(3'b111, 1, -1, 1'b0);
    run_pass(3'b000, 0, -1, 1'b0);
    run_pass(3'b111, 0, 42, 1'b0);
    run_pass(3'b111, 0, -1, 1'b0);

    // Asynchronous reset while cnt = 20 is being issued
    @(posedge clk); #1;
    q_rd0.delete();
    comp_mask = 3'b001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    g = 0;
    while (q_rd0.size() < 20 && g < 100) begin @(posedge clk); #1; g++; end
    chk("arst_reach_cnt20", q_rd0.size(), 20);
    chk("arst_pre_busy", busy0, 1);
    #2 arst = 1'b1;
    #1;
    chk("arst_rd_en", rd_en0, 0);
    chk("arst_addr", addr0, 0);
    chk("arst_en0", en0, 0);
    chk("arst_en1", en1, 0);
    chk("arst_cnt_dc0", cnt0, 0);
    chk("arst_cnt_dc1", cnt1, 0);
    chk("arst_cidx", ci0, 0);
    chk("arst_clr_n", clrn0, 1);
    chk("arst_busy0", busy0, 0);
    chk("arst_busy1", busy1, 0);
    chk("arst_done", done0, 0);
    @(posedge clk); #1;
    arst = 1'b0;
    run_pass(3'b001, 0, -1, 1'b0);

    // start together with abort in IDLE must not begin a pass
    @(posedge clk); #1;
    q_rd0.delete(); bc = n_clr0;
    comp_mask = 3'b111; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy0, 0);
    chk("start_abort_clr_n", clrn0, 1);
    repeat (4) begin @(posedge clk); #1; end
    chk("start_abort_reads", q_rd0.size(), 0);
    chk("start_abort_clr_cnt", n_clr0 - bc, 0);

    for (int r = 0; r < 4; r++) begin
      m = 3'($urandom);
      run_pass(m, 2, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
